// File: rtl/rng_word_server.sv
// rng_word_server: drives the ChaCha keystream core one block at a time and
// serves each 512-bit block as sixteen 32-bit words on a valid/ready port.
// The next block is fetched while the current one drains.
// Optional build macro RNG_HEALTH_EN enables a repeated-block health test
// with a sticky rng_fault; without it rng_fault is tied low.
//
// state  | meaning
// S_KICK | ks_reset high for one cycle to start the core on ks_nonce
// S_FILL | core running or finished; capture when the buffer can take it
module rng_word_server (
   input  logic         clk,
   input  logic         Reset,
   input  logic [127:0] nonce_seed,
   input  logic [511:0] ks_stream,
   input  logic         ks_done,
   output logic         ks_reset,
   output logic [127:0] ks_nonce,
   output logic [31:0]  rnd_word,
   output logic         rnd_valid,
   input  logic         rnd_ready,
   output logic         rng_fault
);

   typedef enum logic {S_KICK, S_FILL} state_t;

   state_t       state, state_nxt;
   logic [511:0] blk_buf;
   logic         buf_full;
   logic [3:0]   idx;
   logic         handshake;
   logic         last_take;
   logic         capture;

   // Outputs depend only on registered state (and Reset), never on rnd_ready.
   // Word i sits at bits [511-32i -: 32]; ~idx == 15-idx picks that slice.
   assign ks_reset  = Reset | (state == S_KICK);
   assign rnd_valid = buf_full & ~rng_fault & ~Reset;
   assign rnd_word  = Reset ? 32'd0 : blk_buf[{~idx, 5'b00000} +: 32];

   assign handshake = rnd_valid & rnd_ready;
   assign last_take = handshake & (idx == 4'd15);

   // Generator state register.
   always_ff @(posedge clk) begin
      if (Reset) state <= S_KICK;
      else       state <= state_nxt;
   end

   // Next-state and capture decision; a leftover ks_done in S_KICK is ignored.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         S_KICK: state_nxt = S_FILL;
         S_FILL: begin
            if (ks_done && (!buf_full || last_take)) begin
               capture   = 1'b1;
               state_nxt = S_KICK;
            end
         end
         default: state_nxt = S_KICK;
      endcase
   end

   // Block buffer, nonce and drain index; a capture overrides the last-word
   // handshake so the new block follows with no bubble.
   always_ff @(posedge clk) begin
      if (Reset) begin
         ks_nonce <= nonce_seed;
         blk_buf  <= '0;
         buf_full <= 1'b0;
         idx      <= 4'd0;
      end else if (capture) begin
         ks_nonce <= ks_nonce + 128'd1;
         blk_buf  <= ks_stream;
         buf_full <= 1'b1;
         idx      <= 4'd0;
      end else if (handshake) begin
         idx <= idx + 4'd1;
         if (idx == 4'd15) buf_full <= 1'b0;
      end
   end

`ifdef RNG_HEALTH_EN
   logic [511:0] hist_blk;
   logic         hist_vld;
   logic         fault_q;

   // Flag a block identical to the previous one; the first block after Reset
   // has nothing to compare against.
   always_ff @(posedge clk) begin
      if (Reset) begin
         hist_blk <= '0;
         hist_vld <= 1'b0;
         fault_q  <= 1'b0;
      end else if (capture) begin
         hist_blk <= ks_stream;
         hist_vld <= 1'b1;
         if (hist_vld && (ks_stream == hist_blk)) fault_q <= 1'b1;
      end
   end

   assign rng_fault = fault_q;
`else
   assign rng_fault = 1'b0;
`endif

endmodule
